// File: rtl/spike_rate_decoder_if.sv
// rtl/spike_rate_decoder_if.sv - rate readout stream interface (valid/ready, channel-tagged)
interface spike_rate_decoder_if #(
    parameter int N_CH = 10
) ();
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_data;
    logic [CH_W-1:0] out_ch;
    logic            out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_ch,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ch,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike counter streaming Q6.10 per-channel rates
module spike_rate_decoder #(
    parameter int N_CH      = 10,
    parameter int WINDOW    = 32,
    parameter int FRAC_BITS = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_CH-1:0]        spikes_in,
    spike_rate_decoder_if.master   rd,
    output logic                   overrun
);
    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int WC_W  = $clog2(WINDOW);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    // count == WINDOW must land exactly on 1.0, hence the shift by the window exponent
    localparam int SHIFT = FRAC_BITS - $clog2(WINDOW);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt      [N_CH];
    logic [CNT_W-1:0] r_shadow   [N_CH];
    logic [CNT_W-1:0] w_cnt_next [N_CH];
    logic [WC_W-1:0]  r_wcnt;
    logic [CH_W-1:0]  r_ch;
    logic [CH_W-1:0]  w_ch_next;
    logic             r_overrun;
    logic             w_win_end;
    logic             w_xfer;
    logic             w_last;
    logic             w_load;
    logic             w_ovr_set;
    logic [CNT_W-1:0] w_sel;

    // Count including the current sample, so the snapshot taken at window end sees it
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            w_cnt_next[k] = r_cnt[k] + CNT_W'(spikes_in[k]);
        end
    end

    assign w_win_end = en && (r_wcnt == WC_LAST);
    assign w_xfer    = (r_state == S_SEND) && rd.out_ready;
    assign w_last    = (r_ch == CH_LAST);

    // Spike and window counters run regardless of the readout state
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N_CH; k++) begin
                r_cnt[k] <= '0;
            end
            r_wcnt <= '0;
        end else if (en) begin
            for (int k = 0; k < N_CH; k++) begin
                r_cnt[k] <= w_win_end ? '0 : w_cnt_next[k];
            end
            r_wcnt <= w_win_end ? '0 : r_wcnt + 1'b1;
        end
    end

    // Readout state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Readout next state: snapshot on window end unless a stream is still in flight
    always_comb begin
        w_state_next = r_state;
        w_ch_next    = r_ch;
        w_load       = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_end) begin
                    w_load       = 1'b1;
                    w_ch_next    = '0;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_xfer && w_last) begin
                    w_ch_next = '0;
                    if (w_win_end) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        w_ch_next = r_ch + 1'b1;
                    end
                    if (w_win_end) begin
                        w_ovr_set = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_ch_next    = '0;
            end
        endcase
    end

    // Channel pointer, shadow snapshot and sticky overrun flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ch      <= '0;
            r_overrun <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            r_ch <= w_ch_next;
            if (w_load) begin
                for (int k = 0; k < N_CH; k++) begin
                    r_shadow[k] <= w_cnt_next[k];
                end
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign w_sel        = r_shadow[r_ch];
    assign rd.out_valid = (r_state == S_SEND);
    assign rd.out_data  = 16'(w_sel) << SHIFT;
    assign rd.out_ch    = r_ch;
    assign rd.out_last  = (r_state == S_SEND) && w_last;
    assign overrun      = r_overrun;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - scoreboard bench for spike_rate_decoder
module tb_spike_rate_decoder;
    localparam int N_CH      = 10;
    localparam int WINDOW    = 32;
    localparam int FRAC_BITS = 10;
    localparam int SHIFT     = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N_CH-1:0] spikes_in;
    logic            overrun;

    spike_rate_decoder_if #(.N_CH(N_CH)) rd_if ();

    spike_rate_decoder #(
        .N_CH(N_CH),
        .WINDOW(WINDOW),
        .FRAC_BITS(FRAC_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .spikes_in(spikes_in),
        .rd(rd_if),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  ch;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          m_cnt [N_CH];
    int          m_wcnt;
    logic        m_overrun;
    logic [15:0] seen_data [N_CH];
    int          n_checks;
    int          n_fail;

    task automatic model_clear();
        exp_q.delete();
        for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
        m_wcnt    = 0;
        m_overrun = 1'b0;
    endtask

    task automatic step(input logic i_en, input logic [N_CH-1:0] i_sp, input logic i_ready);
        beat_t b;
        @(negedge clk);
        en               = i_en;
        spikes_in        = i_sp;
        rd_if.out_ready  = i_ready;
        #1;
        if (rd_if.out_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got ch=%0d data=%h, required no valid", rd_if.out_ch, rd_if.out_data);
            end else begin
                b = exp_q[0];
                if (rd_if.out_data !== b.data || rd_if.out_ch !== b.ch || rd_if.out_last !== b.last) begin
                    n_fail++;
                    $display("FAIL beat: got data=%h ch=%0d last=%b, required data=%h ch=%0d last=%b",
                             rd_if.out_data, rd_if.out_ch, rd_if.out_last, b.data, b.ch, b.last);
                end
                if (i_ready) begin
                    seen_data[b.ch] = rd_if.out_data;
                    void'(exp_q.pop_front());
                end
            end
        end
        if (i_en) begin
            for (int k = 0; k < N_CH; k++) m_cnt[k] += int'(i_sp[k]);
            m_wcnt++;
            if (m_wcnt == WINDOW) begin
                m_wcnt = 0;
                if (exp_q.size() == 0) begin
                    for (int k = 0; k < N_CH; k++) begin
                        b.data = 16'(m_cnt[k] << SHIFT);
                        b.ch   = 4'(k);
                        b.last = (k == N_CH - 1);
                        exp_q.push_back(b);
                    end
                end else begin
                    m_overrun = 1'b1;
                end
                for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rd_if.out_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b, required %b", rd_if.out_valid, exp_q.size() != 0);
        end
        n_checks++;
        if (overrun !== m_overrun) begin
            n_fail++;
            $display("FAIL overrun: got %b, required %b", overrun, m_overrun);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b0;
        en              = 1'b0;
        spikes_in       = '0;
        rd_if.out_ready = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        n_checks++;
        if (rd_if.out_valid !== 1'b0 || rd_if.out_data !== 16'h0000 || rd_if.out_ch !== 4'd0 ||
            rd_if.out_last !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b data=%h ch=%0d last=%b overrun=%b, required all 0",
                     rd_if.out_valid, rd_if.out_data, rd_if.out_ch, rd_if.out_last, overrun);
        end
        rst = 1'b1;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            step(1'b0, '0, 1'b1);
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_zero();
        for (int i = 0; i < WINDOW; i++) step(1'b1, '0, 1'b1);
        n_checks++;
        if (rd_if.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_latency: got out_valid=%b, required 1", rd_if.out_valid);
        end
        drain();
        n_checks++;
        if (seen_data[9] !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_data: got %h, required 0000", seen_data[9]);
        end
    endtask

    task automatic test_rates();
        logic [N_CH-1:0] sp;
        for (int i = 0; i < WINDOW; i++) begin
            sp    = '0;
            sp[3] = 1'b1;
            sp[0] = (i % 2 == 0);
            step(1'b1, sp, 1'b1);
        end
        drain();
        n_checks++;
        if (seen_data[3] !== 16'h0400 || seen_data[0] !== 16'h0200 || seen_data[5] !== 16'h0000) begin
            n_fail++;
            $display("FAIL rates: got ch3=%h ch0=%h ch5=%h, required 0400 0200 0000",
                     seen_data[3], seen_data[0], seen_data[5]);
        end
    endtask

    task automatic test_stall();
        int   stalls = 0;
        int   guard  = 0;
        logic rdy;
        for (int i = 0; i < WINDOW; i++) step(1'b1, N_CH'($urandom), 1'b1);
        while (exp_q.size() != 0 && guard < 100) begin
            rdy = 1'b1;
            if (exp_q[0].ch == 4'd4 && stalls < 5) begin
                rdy = 1'b0;
                stalls++;
            end
            step(1'b0, '0, rdy);
            guard++;
        end
        n_checks++;
        if (stalls != 5 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall: got stalls=%0d outstanding=%0d, required 5 and 0", stalls, exp_q.size());
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 2 * WINDOW; i++) step(1'b1, N_CH'($urandom), 1'b0);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %b, required 1", overrun);
        end
        drain();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b, required 1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(exp_q.size() == 5) && guard < 200) begin
            step(1'b1, N_CH'($urandom), 1'b1);
            guard++;
        end
        do_reset();
        for (int i = 0; i < WINDOW - 1; i++) step(1'b1, N_CH'($urandom), 1'b0);
        n_checks++;
        if (rd_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_early: got out_valid=%b, required 0", rd_if.out_valid);
        end
        step(1'b1, N_CH'($urandom), 1'b0);
        n_checks++;
        if (rd_if.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_window: got out_valid=%b, required 1", rd_if.out_valid);
        end
        drain();
    endtask

    task automatic test_coincide();
        do_reset();
        for (int i = 0; i < WINDOW; i++) step(1'b1, N_CH'($urandom), 1'b0);
        for (int j = 0; j < WINDOW; j++) step(1'b1, N_CH'($urandom), j >= WINDOW - N_CH);
        n_checks++;
        if (rd_if.out_valid !== 1'b1 || rd_if.out_ch !== 4'd0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL coincide: got valid=%b ch=%0d overrun=%b, required 1 0 0",
                     rd_if.out_valid, rd_if.out_ch, overrun);
        end
        drain();
    endtask

    task automatic test_en_toggle();
        do_reset();
        for (int i = 0; i < 2 * WINDOW; i++) step(i % 2 == 1, N_CH'($urandom), 1'($urandom));
        n_checks++;
        if (rd_if.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL en_toggle_window: got out_valid=%b, required 1", rd_if.out_valid);
        end
        drain();
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        en              = 1'b0;
        spikes_in       = '0;
        rd_if.out_ready = 1'b0;
        for (int k = 0; k < N_CH; k++) seen_data[k] = 16'hxxxx;
        model_clear();
        test_reset();
        test_zero();
        test_rates();
        test_stall();
        test_overrun();
        test_reset_mid();
        test_coincide();
        test_en_toggle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
